// File: rtl/ps2_line_serializer_pkg.sv
// Shared definitions for the PS/2 line serializer and its companion line receiver:
// FSM encoding, line geometry defaults and the characters that end a line.
package ps2_line_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } line_state_t;

  localparam int         LINE_CHARS_DEF = 32;
  localparam logic [7:0] TERM_CHAR_DEF  = 8'h0a;
  localparam logic [7:0] NUL_CHAR       = 8'h00;

  // A NUL or the terminator itself ends the printable part of a line.
  function automatic logic is_line_end(input logic [7:0] c, input logic [7:0] term);
    return (c == NUL_CHAR) || (c == term);
  endfunction

endpackage

// File: rtl/ps2_line_serializer.sv
// Captures a fixed-width line of characters and streams it out one byte per
// valid/ready handshake, stopping at the first NUL/terminator and appending TERM_CHAR.
module ps2_line_serializer
  import ps2_line_serializer_pkg::*;
#(
  parameter int         LINE_CHARS = LINE_CHARS_DEF,
  parameter logic [7:0] TERM_CHAR  = TERM_CHAR_DEF
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [8*LINE_CHARS-1:0] line_in,
  input  logic                    line_load,
  input  logic                    char_ready,
  output logic                    busy,
  output logic [7:0]              char_out,
  output logic                    char_valid,
  output logic                    line_done
);

  localparam int                 IDX_W    = $clog2(LINE_CHARS + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LINE_CHARS);

  line_state_t             state, state_n;
  logic [IDX_W-1:0]        idx, idx_n, idx_inc;
  logic [8*LINE_CHARS-1:0] shadow, shadow_n;

  logic [7:0] char_n;
  logic       valid_n;
  logic       busy_n;
  logic       done_n;

  // Slot k sits at the top end of the line for k=0; positions past the line read as NUL.
  function automatic logic [7:0] slot_at(input logic [8*LINE_CHARS-1:0] line,
                                         input logic [IDX_W-1:0]        i);
    if (i >= LAST_IDX) return NUL_CHAR;
    return line[8*(LINE_CHARS - int'(i)) - 1 -: 8];
  endfunction

  assign idx_inc = idx + IDX_W'(1);

  // Next-state logic. On a transfer the following slot is inspected so the
  // terminator follows the last printable character with no idle gap.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    case (state)
      ST_IDLE: begin
        if (line_load) begin
          shadow_n = line_in;
          idx_n    = '0;
          state_n  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!char_valid) begin
          state_n = ST_TERM;
        end else if (char_ready) begin
          idx_n = idx_inc;
          if ((idx_inc == LAST_IDX) || is_line_end(slot_at(shadow, idx_inc), TERM_CHAR))
            state_n = ST_TERM;
        end
      end
      ST_TERM: begin
        if (char_ready) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so the outputs leave a flop.
  always_comb begin
    char_n  = NUL_CHAR;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state_n)
      ST_SEND: begin
        char_n  = slot_at(shadow_n, idx_n);
        valid_n = !is_line_end(char_n, TERM_CHAR);
        busy_n  = 1'b1;
      end
      ST_TERM: begin
        char_n  = TERM_CHAR;
        valid_n = 1'b1;
        busy_n  = 1'b1;
      end
      ST_DONE: done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shadow     <= '0;
      char_out   <= NUL_CHAR;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      line_done  <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      char_out   <= char_n;
      char_valid <= valid_n;
      busy       <= busy_n;
      line_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_ps2_line_serializer.sv
// Directed bench for ps2_line_serializer: a transfer-level model checked every cycle,
// plus literal expectations on the emitted byte stream, busy length and done pulses.
module tb_ps2_line_serializer;

  localparam int         LC   = 32;
  localparam logic [7:0] TERM = 8'h0a;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [8*LC-1:0] line_in = '0;
  logic            line_load = 1'b0;
  logic            char_ready = 1'b0;
  logic            busy;
  logic [7:0]      char_out;
  logic            char_valid;
  logic            line_done;

  ps2_line_serializer #(.LINE_CHARS(LC), .TERM_CHAR(TERM)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .line_in    (line_in),
    .line_load  (line_load),
    .char_ready (char_ready),
    .busy       (busy),
    .char_out   (char_out),
    .char_valid (char_valid),
    .line_done  (line_done)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: the expected byte stream of the current line, plus an idle cycle when slot 0 already ends it.
  byte unsigned exp_q[$];
  logic         m_active = 1'b0;
  logic         m_bubble = 1'b0;
  logic         m_done   = 1'b0;
  logic [7:0]   m_bubble_char = 8'h00;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      m_active = 1'b0;
      m_bubble = 1'b0;
      m_done   = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (char_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (line_load) begin
      exp_q.delete();
      for (int k = 0; k < LC; k++) begin
        logic [7:0] c;
        c = line_in[8*(LC-k)-1 -: 8];
        if (c == 8'h00 || c == TERM) break;
        exp_q.push_back(c);
      end
      exp_q.push_back(TERM);
      m_bubble_char = line_in[8*LC-1 -: 8];
      m_bubble      = (m_bubble_char == 8'h00) || (m_bubble_char == TERM);
      m_active      = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      check("busy", busy, m_active);
      check("char_valid", char_valid, m_active && !m_bubble);
      check("char_out", char_out, !m_active ? 8'h00 : (m_bubble ? m_bubble_char : exp_q[0]));
      check("line_done", line_done, m_done);
    end
  end

  byte unsigned log_q[$];
  int busy_cnt = 0;
  int done_cnt = 0;

  always @(posedge clock)
    if (resetn && char_valid && char_ready) log_q.push_back(char_out);

  always @(negedge clock) begin
    if (resetn && busy) busy_cnt++;
    if (resetn && line_done) done_cnt++;
  end

  task automatic fill_line(input string s);
    line_in = '0;
    for (int k = 0; k < s.len() && k < LC; k++) line_in[8*(LC-k)-1 -: 8] = s[k];
  endtask

  task automatic begin_test();
    log_q.delete();
    busy_cnt = 0;
  endtask

  task automatic load_line();
    @(negedge clock); #1;
    line_load = 1'b1;
    @(negedge clock); #1;
    line_load = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock); #2;
      if (done_cnt != d0) break;
    end
    check({name, "_finished"}, done_cnt != d0, 1);
    @(negedge clock); #2;
    check({name, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic check_log(input string name, input string s);
    check({name, "_count"}, log_q.size(), s.len() + 1);
    for (int k = 0; k <= s.len(); k++) begin
      if (k < log_q.size())
        check({name, "_byte"}, log_q[k], (k < s.len()) ? s[k] : TERM);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int    d0;
    logic  found;

    #12;
    check("reset_busy", busy, 0);
    check("reset_char_valid", char_valid, 0);
    check("reset_char_out", char_out, 8'h00);
    check("reset_line_done", line_done, 0);
    @(negedge clock); #1;
    resetn     = 1'b1;
    char_ready = 1'b1;
    repeat (2) @(negedge clock);

    // "AB" at full rate: 41, 42, 0a back to back
    fill_line("AB");
    begin_test();
    load_line();
    run_until_done("ab", 20);
    check_log("ab", "AB");
    check("ab_busy_cycles", busy_cnt, 3);

    // "AB" with 0x42 back-pressured for 4 cycles
    fill_line("AB");
    begin_test();
    @(negedge clock); #1; line_load = 1'b1;
    @(negedge clock); #1; line_load = 1'b0;
    @(negedge clock); #1; char_ready = 1'b0;
    check("stall_start_char", char_out, 8'h42);
    repeat (4) @(negedge clock);
    #1;
    check("stall_hold_char", char_out, 8'h42);
    check("stall_hold_valid", char_valid, 1);
    char_ready = 1'b1;
    run_until_done("stall", 20);
    check_log("stall", "AB");
    check("stall_busy_cycles", busy_cnt, 7);

    // Full line of 'a' with no NUL
    s = "";
    for (int k = 0; k < LC; k++) s = {s, "a"};
    fill_line(s);
    begin_test();
    load_line();
    run_until_done("full", 60);
    check_log("full", s);
    check("full_busy_cycles", busy_cnt, 33);

    // All-zero line: only the terminator
    line_in = '0;
    begin_test();
    load_line();
    run_until_done("zero", 20);
    check_log("zero", "");
    check("zero_busy_cycles", busy_cnt, 2);

    // Embedded terminator stops the line and is not repeated
    fill_line("A\nB");
    begin_test();
    load_line();
    run_until_done("embterm", 20);
    check_log("embterm", "A");
    check("embterm_busy_cycles", busy_cnt, 2);

    // Terminator in slot 0
    fill_line("\nA");
    begin_test();
    load_line();
    run_until_done("leadterm", 20);
    check_log("leadterm", "");
    check("leadterm_busy_cycles", busy_cnt, 2);

    // Reset while slot 5 is offered
    fill_line("ABCDEFGHIJ");
    begin_test();
    load_line();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (char_out == 8'h46) begin found = 1'b1; break; end
      @(negedge clock); #1;
    end
    check("midreset_reached_slot5", found, 1);
    d0 = done_cnt;
    #2 resetn = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_char_valid", char_valid, 0);
    check("midreset_char_out", char_out, 8'h00);
    check("midreset_line_done", line_done, 0);
    @(posedge clock);
    @(negedge clock); #1;
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    check("midreset_no_done", done_cnt - d0, 0);
    fill_line("XY");
    begin_test();
    load_line();
    run_until_done("xy", 20);
    check_log("xy", "XY");

    // New line_in and line_load during emission are ignored
    fill_line("HELLO");
    begin_test();
    load_line();
    fill_line("ZZZZZZZZ");
    line_load = 1'b1;
    repeat (2) @(negedge clock);
    #1 line_load = 1'b0;
    run_until_done("reload", 30);
    check_log("reload", "HELLO");

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_line_serializer.md
PS2_LINE_SERIALIZER -- requirements
Module: ps2_line_serializer

Interface
REQ-001 Parameter LINE_CHARS, default 32, SHALL be the number of 8-bit character slots in one line.
REQ-002 Parameter TERM_CHAR, default 8'h0a, SHALL be the end-of-line character emitted after every line.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 line_in  input  8*LINE_CHARS  SHALL carry the line: slot 0 in [8*LINE_CHARS-1 -: 8], slot k in [8*(LINE_CHARS-k)-1 -: 8].
REQ-006 line_load  input  1  SHALL be a request strobe to capture line_in and begin emission.
REQ-007 busy  output  1  SHALL be high while a line is held and not yet fully emitted.
REQ-008 char_out  output  8  SHALL be the current character offered downstream.
REQ-009 char_valid  output  1  SHALL be high when char_out holds a character to transfer.
REQ-010 char_ready  input  1  SHALL be the downstream acceptance signal.
REQ-011 line_done  output  1  SHALL pulse high for exactly one cycle when a line completes.

Function
REQ-012 States SHALL be IDLE, SEND, TERM, DONE.
REQ-013 Transfer SHALL occur on a rising edge where char_valid and char_ready are both high.
REQ-014 IDLE: when line_load is high at an edge, the block SHALL capture line_in into a shadow register, set index=0, and enter SEND; otherwise it SHALL stay in IDLE.
REQ-015 line_load SHALL be ignored in every state except IDLE; later changes to line_in SHALL NOT affect a captured line.
REQ-016 SEND: char_out SHALL equal the shadow slot at index; char_valid SHALL be high unless that slot is 8'h00 or TERM_CHAR.
REQ-017 SEND with slot equal to 8'h00 or TERM_CHAR SHALL move to TERM on the next edge without a transfer, so TERM_CHAR is never emitted twice.
REQ-018 SEND with a transfer SHALL increment index; if the incremented index equals LINE_CHARS, the state SHALL move to TERM.
REQ-019 TERM: char_out SHALL be TERM_CHAR and char_valid high; on transfer the state SHALL move to DONE.
REQ-020 DONE SHALL last one cycle with line_done=1 and busy=0, then return to IDLE; DONE SHALL ignore line_load.
REQ-021 char_out and char_valid SHALL hold stable while char_valid=1 and char_ready=0 (no drop, no skip).
REQ-022 busy SHALL be high in SEND and TERM only.
REQ-023 Index SHALL be clog2(LINE_CHARS+1) bits wide and SHALL never exceed LINE_CHARS.
REQ-024 Latency: line_load sampled at edge N SHALL give char_valid high in the cycle after edge N, when slot 0 is printable.
REQ-025 With char_ready held high, one character SHALL transfer per cycle; a full line SHALL take LINE_CHARS+1 transfers.
REQ-026 The block SHALL perform no arithmetic on character values; bytes SHALL pass through unmodified.

Reset
REQ-027 resetn low SHALL immediately force state=IDLE, index=0, shadow=0, char_out=8'h00, char_valid=0, busy=0, line_done=0, regardless of clock.
REQ-028 Reset mid-line SHALL discard the line; no line_done SHALL be produced for it.
REQ-029 The first line_load after resetn deasserts SHALL start emission at slot 0.

Structure
REQ-030 The state encoding, LINE_CHARS default, TERM_CHAR and the NUL constant 8'h00 SHALL live in a shared package also used by the line receiver.
REQ-031 The block SHALL be a single module with no sub-modules; slot selection SHALL be an indexed part-select of the shadow register.

Verification
REQ-032 line "AB" (0x41,0x42, rest 0), char_ready=1 -> char_out 0x41, 0x42, 0x0a on 3 consecutive cycles; line_done pulses the following cycle.
REQ-033 Same line, char_ready low for 4 cycles while 0x42 is offered -> 0x42 held stable with char_valid=1; then 0x42, 0x0a each emitted exactly once.
REQ-034 32 slots of 0x61, no NUL -> 32 transfers of 0x61, then 0x0a; 33 transfers total, busy high for 33 cycles.
REQ-035 all-zero line -> single 0x0a transfer, then line_done.
REQ-036 resetn pulsed low during slot 5 -> all outputs 0 within the low phase; next load of "XY" emits 0x58, 0x59, 0x0a.
REQ-037 line_load re-asserted with a new line_in during SEND -> ignored; the original line is emitted intact.
